mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_lsu_align.sv | 59 +++++
 rtl/mem_stage_lsu.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MEM stage load/store unit:
//   - bit positions inside the 5-bit mem_op field {load, store, unsigned, size[1:0]}
//   - access size encodings
//   - the access FSM state type
//   - the alignment rule, shared by the stage control and the lane logic
package mem_stage_pkg;

  localparam int OP_LOAD  = 4;
  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  // Halfwords need an even address and words a 4-byte aligned one.
  // Size encoding 3 is unused by decode and is treated like a word.
  function automatic logic isMisaligned(input logic [1:0] addrOff, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addrOff[0];
      default: bad = (addrOff != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align
//   Purely combinational byte-lane logic for data-memory accesses.
//   Ports:
//     i_addrOff  [1:0]  low two bits of the byte address
//     i_size     [1:0]  access size (SZ_B / SZ_H / SZ_W)
//     i_unsigned        zero-extend loads instead of sign-extending
//     i_sdata    [31:0] store data (register value)
//     i_rdata    [31:0] raw read data from the bus
//     o_ale             access is misaligned
//     o_wstrb    [3:0]  byte strobes for a store
//     o_wdata    [31:0] store data replicated into every lane
//     o_ldata    [31:0] extracted and extended load value
module mem_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_addrOff,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic        o_ale,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection for both directions. Store data is replicated so the
  // strobes alone pick the lane; load data is shifted down from the lane
  // the address points at and then extended to 32 bits.
  always_comb begin
    o_ale   = isMisaligned(i_addrOff, i_size);
    w_byte  = i_rdata[{i_addrOff, 3'b000} +: 8];
    w_half  = i_rdata[{i_addrOff[1], 4'b0000} +: 16];
    o_wstrb = 4'b1111;
    o_wdata = i_sdata;
    o_ldata = i_rdata;
    case (i_size)
      SZ_B: begin
        o_wstrb = 4'b0001 << i_addrOff;
        o_wdata = {4{i_sdata[7:0]}};
        o_ldata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_wstrb = 4'b0011 << i_addrOff;
        o_wdata = {2{i_sdata[15:0]}};
        o_ldata = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_sdata;
        o_ldata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM pipeline stage that owns the data-memory access. Issues requests on a
//   req/addr_ok/data_ok bus, stalls while an access is outstanding, buffers
//   load data when WB is not ready, and flags misaligned loads/stores.
//   Ports:
//     clk, reset                       clock, async active-high reset
//     exe_to_mem_valid / mem_allowin   EXE->MEM handshake
//     exe_rf_all, exe_pc, exe_result,  instruction fields from EXE
//     exe_mem_op, exe_rkd_value
//     wb_allowin / mem_to_wb_valid     MEM->WB handshake
//     mem_rf_all, mem_pc               result towards WB (also forwarding source)
//     mem_ale, mem_badv                misaligned-access exception info
//     data_*                           data bus request/response
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exe_to_mem_valid,
  output logic                   mem_allowin,
  input  logic [RF_ADDR_W:0]     exe_rf_all,
  input  logic [31:0]            exe_pc,
  input  logic [31:0]            exe_result,
  input  logic [4:0]             exe_mem_op,
  input  logic [31:0]            exe_rkd_value,
  input  logic                   wb_allowin,
  output logic                   mem_to_wb_valid,
  output logic [RF_ADDR_W+32:0]  mem_rf_all,
  output logic [31:0]            mem_pc,
  output logic                   mem_ale,
  output logic [31:0]            mem_badv,
  output logic                   data_req,
  output logic                   data_wr,
  output logic [3:0]             data_wstrb,
  output logic [ADDR_W-1:0]      data_addr,
  output logic [31:0]            data_wdata,
  input  logic                   data_addr_ok,
  input  logic [31:0]            data_rdata,
  input  logic                   data_data_ok
);

  logic                 r_valid;
  logic [31:0]          r_pc;
  logic [31:0]          r_result;
  logic [31:0]          r_rkd;
  logic [RF_ADDR_W:0]   r_rfAll;
  logic [4:0]           r_memOp;
  logic [31:0]          r_buf;
  lsu_state_t           r_state;

  logic                 w_isMem;
  logic                 w_ale;
  logic                 w_readyGo;
  logic                 w_latch;
  logic                 w_newReq;
  logic [3:0]           w_wstrb;
  logic [31:0]          w_wdata;
  logic [31:0]          w_ldata;
  logic [31:0]          w_rfWdata;

  mem_lsu_align u_align (
    .i_addrOff  (r_result[1:0]),
    .i_size     (r_memOp[1:0]),
    .i_unsigned (r_memOp[OP_UNS]),
    .i_sdata    (r_rkd),
    .i_rdata    (data_rdata),
    .o_ale      (w_ale),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  assign w_isMem = r_memOp[OP_LOAD] | r_memOp[OP_STORE];
  assign w_latch = exe_to_mem_valid & mem_allowin;

  // Decide at latch time whether the incoming instruction needs a bus access,
  // so the request goes out in the very first cycle it sits in MEM.
  assign w_newReq = (exe_mem_op[OP_LOAD] | exe_mem_op[OP_STORE])
                  & ~isMisaligned(exe_result[1:0], exe_mem_op[1:0]);

  // A memory instruction may leave once its response arrives (or was
  // buffered); misaligned ones never touch the bus and leave at once.
  assign w_readyGo = ~w_isMem | w_ale
                   | ((r_state == S_WAIT) & data_data_ok)
                   | (r_state == S_DONE);

  assign mem_allowin     = ~r_valid | (w_readyGo & wb_allowin);
  assign mem_to_wb_valid = r_valid & w_readyGo;

  assign mem_ale  = r_valid & w_isMem & w_ale;
  assign mem_badv = mem_ale ? r_result : 32'd0;
  assign mem_pc   = r_pc;

  // Once the response has been parked the bus data may change, so DONE
  // always returns the buffered value.
  assign w_rfWdata  = r_memOp[OP_LOAD] ? ((r_state == S_DONE) ? r_buf : w_ldata) : r_result;
  assign mem_rf_all = {r_rfAll[RF_ADDR_W] & ~(w_isMem & w_ale), r_rfAll[RF_ADDR_W-1:0], w_rfWdata};

  assign data_req   = (r_state == S_REQ);
  assign data_wr    = r_memOp[OP_STORE];
  assign data_wstrb = w_wstrb & {4{r_memOp[OP_STORE]}};
  assign data_wdata = w_wdata;

  generate
    if (ADDR_W > 32) begin : g_addrExt
      assign data_addr = {{(ADDR_W-32){1'b0}}, r_result};
    end else begin : g_addrTrunc
      assign data_addr = r_result[ADDR_W-1:0];
    end
  endgenerate

  // Pipeline register: instruction fields are captured only on a real
  // handshake, while the valid bit follows EXE whenever MEM can accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_pc     <= 32'd0;
      r_result <= 32'd0;
      r_rkd    <= 32'd0;
      r_rfAll  <= '0;
      r_memOp  <= 5'd0;
    end else begin
      if (mem_allowin) begin
        r_valid <= exe_to_mem_valid;
      end
      if (w_latch) begin
        r_pc     <= exe_pc;
        r_result <= exe_result;
        r_rkd    <= exe_rkd_value;
        r_rfAll  <= exe_rf_all;
        r_memOp  <= exe_mem_op;
      end
    end
  end

  // Access FSM. A new instruction can only be latched when the previous one
  // is leaving, so the latch case takes priority and gives back-to-back
  // requests with no bubble. Responses outside WAIT are simply ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_buf   <= 32'd0;
    end else if (w_latch) begin
      r_state <= w_newReq ? S_REQ : S_IDLE;
    end else begin
      case (r_state)
        S_REQ: begin
          if (data_addr_ok) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (wb_allowin) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
              r_buf   <= w_ldata;
            end
          end
        end
        S_DONE: begin
          if (wb_allowin) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//   Directed bench for mem_stage_lsu: drives instructions from the EXE side,
//   plays the data bus by hand and compares outputs against hand-computed
//   values.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_to_mem_valid;
  logic        mem_allowin;
  logic [5:0]  exe_rf_all;
  logic [31:0] exe_pc;
  logic [31:0] exe_result;
  logic [4:0]  exe_mem_op;
  logic [31:0] exe_rkd_value;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [37:0] mem_rf_all;
  logic [31:0] mem_pc;
  logic        mem_ale;
  logic [31:0] mem_badv;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  int errCount   = 0;
  int checkCount = 0;

  // mem_op encodings {load, store, unsigned, size}
  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_LDB  = 5'b10000;
  localparam logic [4:0] OP_LDHU = 5'b10101;
  localparam logic [4:0] OP_LDW  = 5'b10010;
  localparam logic [4:0] OP_STH  = 5'b01001;
  localparam logic [4:0] OP_STW  = 5'b01010;

  mem_stage_lsu #(.ADDR_W(32), .RF_ADDR_W(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_allowin      (mem_allowin),
    .exe_rf_all       (exe_rf_all),
    .exe_pc           (exe_pc),
    .exe_result       (exe_result),
    .exe_mem_op       (exe_mem_op),
    .exe_rkd_value    (exe_rkd_value),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_rf_all       (mem_rf_all),
    .mem_pc           (mem_pc),
    .mem_ale          (mem_ale),
    .mem_badv         (mem_badv),
    .data_req         (data_req),
    .data_wr          (data_wr),
    .data_wstrb       (data_wstrb),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_addr_ok     (data_addr_ok),
    .data_rdata       (data_rdata),
    .data_data_ok     (data_data_ok)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports the ones that disagree.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one instruction from EXE; it is taken on the next edge if MEM allows.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic rfWe, input logic [4:0] rfWaddr, input logic [31:0] pc);
    exe_to_mem_valid = 1'b1;
    exe_mem_op       = op;
    exe_result       = addr;
    exe_rkd_value    = sdata;
    exe_rf_all       = {rfWe, rfWaddr};
    exe_pc           = pc;
  endtask

  // Steps to just after the next rising edge, where new inputs are driven.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    exe_to_mem_valid = 1'b0;
    exe_rf_all       = '0;
    exe_pc           = '0;
    exe_result       = '0;
    exe_mem_op       = '0;
    exe_rkd_value    = '0;
    wb_allowin       = 1'b1;
    data_addr_ok     = 1'b0;
    data_rdata       = '0;
    data_data_ok     = 1'b0;

    // Reset state
    repeat (2) nextCycle();
    checkOutput("rst_req",     data_req,        1'b0);
    checkOutput("rst_valid",   mem_to_wb_valid, 1'b0);
    checkOutput("rst_ale",     mem_ale,         1'b0);
    checkOutput("rst_rfwe",    mem_rf_all[37],  1'b0);
    checkOutput("rst_pc",      mem_pc,          32'd0);
    checkOutput("rst_allowin", mem_allowin,     1'b1);
    reset = 1'b0;

    // Non-memory instruction: one cycle, result passes through
    applyStimulus(OP_NONE, 32'h1234_5678, 32'd0, 1'b1, 5'd7, 32'h1C00_0100);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("alu_valid", mem_to_wb_valid, 1'b1);
    checkOutput("alu_rfall", mem_rf_all, {1'b1, 5'd7, 32'h1234_5678});
    checkOutput("alu_req",   data_req, 1'b0);
    checkOutput("alu_pc",    mem_pc, 32'h1C00_0100);

    // ld.b at 0x1003, signed, addr_ok cycle 1, data_ok cycle 2
    nextCycle();
    applyStimulus(OP_LDB, 32'h0000_1003, 32'd0, 1'b1, 5'd5, 32'h1C00_0104);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b1;
    #1;
    checkOutput("ldb_req",     data_req, 1'b1);
    checkOutput("ldb_wr",      data_wr, 1'b0);
    checkOutput("ldb_addr",    data_addr, 32'h0000_1003);
    checkOutput("ldb_wstrb",   data_wstrb, 4'b0000);
    checkOutput("ldb_c1valid", mem_to_wb_valid, 1'b0);
    checkOutput("ldb_c1allow", mem_allowin, 1'b0);
    nextCycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_0000;
    #1;
    checkOutput("ldb_c2req",   data_req, 1'b0);
    checkOutput("ldb_c2valid", mem_to_wb_valid, 1'b1);
    checkOutput("ldb_rfall",   mem_rf_all, {1'b1, 5'd5, 32'hFFFF_FF80});
    nextCycle();
    data_data_ok = 1'b0;
    #1;
    checkOutput("ldb_gone", mem_to_wb_valid, 1'b0);

    // st.h at 0x2002
    applyStimulus(OP_STH, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 5'd0, 32'h1C00_0108);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b1;
    #1;
    checkOutput("sth_req",   data_req, 1'b1);
    checkOutput("sth_wr",    data_wr, 1'b1);
    checkOutput("sth_wstrb", data_wstrb, 4'b1100);
    checkOutput("sth_wdata", data_wdata, 32'hABCD_ABCD);
    checkOutput("sth_addr",  data_addr, 32'h0000_2002);
    nextCycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    #1;
    checkOutput("sth_valid", mem_to_wb_valid, 1'b1);
    checkOutput("sth_rfwe",  mem_rf_all[37], 1'b0);
    nextCycle();
    data_data_ok = 1'b0;

    // ld.w at 0x3002: misaligned, no request, one cycle
    applyStimulus(OP_LDW, 32'h0000_3002, 32'd0, 1'b1, 5'd9, 32'h1C00_010C);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("ale_req",     data_req, 1'b0);
    checkOutput("ale_flag",    mem_ale, 1'b1);
    checkOutput("ale_badv",    mem_badv, 32'h0000_3002);
    checkOutput("ale_rfwe",    mem_rf_all[37], 1'b0);
    checkOutput("ale_valid",   mem_to_wb_valid, 1'b1);
    checkOutput("ale_allowin", mem_allowin, 1'b1);
    nextCycle();
    checkOutput("ale_gone",    mem_to_wb_valid, 1'b0);
    checkOutput("ale_cleared", mem_ale, 1'b0);

    // ld.hu at 0x4000, data_ok while WB stalls for 3 cycles
    applyStimulus(OP_LDHU, 32'h0000_4000, 32'd0, 1'b1, 5'd3, 32'h1C00_0110);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b1;
    nextCycle();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_8001;
    wb_allowin   = 1'b0;
    #1;
    checkOutput("ldhu_valid",  mem_to_wb_valid, 1'b1);
    checkOutput("ldhu_allow",  mem_allowin, 1'b0);
    checkOutput("ldhu_wdata",  mem_rf_all[31:0], 32'h0000_8001);
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      data_data_ok = (c == 1);
      data_rdata   = (c == 0) ? 32'hDEAD_BEEF : 32'hFFFF_FFFF;
      #1;
      checkOutput("done_wdata", mem_rf_all[31:0], 32'h0000_8001);
      checkOutput("done_allow", mem_allowin, 1'b0);
      checkOutput("done_valid", mem_to_wb_valid, 1'b1);
    end
    // Release WB and immediately offer st.w at 0x5000 (back-to-back)
    nextCycle();
    data_data_ok = 1'b0;
    wb_allowin   = 1'b1;
    applyStimulus(OP_STW, 32'h0000_5000, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h1C00_0114);
    #1;
    checkOutput("rel_allow", mem_allowin, 1'b1);
    checkOutput("rel_wdata", mem_rf_all[31:0], 32'h0000_8001);
    checkOutput("rel_valid", mem_to_wb_valid, 1'b1);

    // st.w: addr_ok held off 4 cycles, request fields must stay put
    nextCycle();
    exe_to_mem_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      data_addr_ok = (c == 4);
      wb_allowin   = !(c == 1 || c == 2);
      data_data_ok = (c == 1);
      #1;
      checkOutput("stw_req",   data_req, 1'b1);
      checkOutput("stw_addr",  data_addr, 32'h0000_5000);
      checkOutput("stw_wstrb", data_wstrb, 4'b1111);
      checkOutput("stw_wdata", data_wdata, 32'hCAFE_F00D);
      checkOutput("stw_wr",    data_wr, 1'b1);
      checkOutput("stw_allow", mem_allowin, 1'b0);
      checkOutput("stw_valid", mem_to_wb_valid, 1'b0);
      nextCycle();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    wb_allowin   = 1'b1;
    #1;
    checkOutput("stw_dreq",  data_req, 1'b0);
    checkOutput("stw_done",  mem_to_wb_valid, 1'b1);
    checkOutput("stw_rfall", mem_rf_all, {1'b0, 5'd0, 32'h0000_5000});
    nextCycle();
    data_data_ok = 1'b0;

    // Reset while REQ drops data_req without waiting for an edge
    applyStimulus(OP_LDB, 32'h0000_7000, 32'd0, 1'b1, 5'd4, 32'h1C00_0118);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    #1;
    checkOutput("rreq_before", data_req, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rreq_async", data_req, 1'b0);
    nextCycle();
    reset = 1'b0;

    // Reset in WAIT, then a stray response after release
    applyStimulus(OP_LDB, 32'h0000_6000, 32'd0, 1'b1, 5'd6, 32'h1C00_011C);
    nextCycle();
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b1;
    nextCycle();
    data_addr_ok = 1'b0;
    reset        = 1'b1;
    #1;
    checkOutput("rwait_req",   data_req, 1'b0);
    checkOutput("rwait_valid", mem_to_wb_valid, 1'b0);
    nextCycle();
    reset        = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h0000_00AA;
    #1;
    checkOutput("stray_valid", mem_to_wb_valid, 1'b0);
    checkOutput("stray_req",   data_req, 1'b0);
    checkOutput("stray_allow", mem_allowin, 1'b1);
    nextCycle();
    data_data_ok = 1'b0;
    #1;
    checkOutput("stray_after", mem_to_wb_valid, 1'b0);
    checkOutput("stray_pc",    mem_pc, 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
